bsearch_guess: RTL and testbench
================================

# bsearch_guess

Binary-search guesser that drives the probe operand of the team's 4-bit magnitude comparator (`cmp`) and consumes its `lt`/`gt`/`eq` flags to locate an unknown secret operand. It is the requester side of the comparator interface: the comparator judges a guess, and this block decides the next guess. It is the core of the lab's number-guessing demo. It sits between a start pushbutton/controller and a `cmp` instance whose other operand is the secret.

## Interface
- `WIDTH`, default 4: operand width, with search range 0 .. 2^WIDTH-1.
- `SW`, default `$clog2(WIDTH+2)`: step-counter width (localparam, not overridable).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, **synchronous, active-high**.
- `start`  in  1  begin a search; sampled in IDLE and DONE, ignored in PROBE.
- `lt`  in  1  from cmp: guess < secret.
- `gt`  in  1  from cmp: guess > secret.
- `eq`  in  1  from cmp: guess == secret.
- `guess`  out  WIDTH  registered probe operand, wired to cmp `num1`.
- `busy`  out  1  high in PROBE.
- `done`  out  1  high in DONE (level, held until next start or rst).
- `err`  out  1  valid with `done`: flags were inconsistent or the range was exhausted.
- `result`  out  WIDTH  located value; valid when `done && !err`.
- `steps`  out  SW  number of probes evaluated in the last or current search.

## Operation
- FSM states IDLE, PROBE, DONE. Bounds `lo` and `hi` are WIDTH+1 bits unsigned, so out-of-range values are representable.
- **IDLE → PROBE** on `start`:
  - `lo` = 0, `hi` = 2^WIDTH-1, `steps` = 0.
  - `guess` = (lo+hi)>>1, which is 7 for WIDTH=4.
- **PROBE**, each cycle, flags are sampled combinationally against the current `guess`, and `steps` increments:
  - exactly `eq`: `result` = `guess`, `err` = 0, go to DONE.
  - exactly `lt`: `lo` = guess+1.
  - exactly `gt`: `hi` = guess-1. At guess=0 this gives `hi` = 0 in WIDTH+1-bit wrap-free arithmetic, so detect it as `lo` > `hi` by treating guess=0 with `gt` as exhausted.
  - After an `lt`/`gt` update, if the new `lo` > new `hi`, set `err` = 1 and go to DONE. Otherwise `guess` = (new lo + new hi)>>1 and stay in PROBE.
  - Zero or more than one flag asserted: `err` = 1, go to DONE. `steps` still counts that cycle.
- **DONE**: hold `result`, `err` and `steps`.
  - `start` re-enters PROBE with a fresh search, exactly as from IDLE.
  - `start` while in PROBE has no effect.
- **Reset**, at any time including mid-search: state = IDLE, `guess` = 0, `result` = 0, `steps` = 0, `busy` = `done` = `err` = 0, `lo` = 0, `hi` = 0.
- `result` is not updated on an error exit; it holds its previous value.

## Timing
- `start` high at edge k puts the first guess on `guess` and asserts `busy` after edge k.
- Each probe takes one cycle. Comparator flags must settle combinationally within the same cycle.
- With a consistent comparator, a search takes at most WIDTH+1 probes: 5 for WIDTH=4. `done` rises the edge after the final probe cycle.
- `busy` and `done` are never high together.
- `done` and `busy` are both low only in IDLE.

## Structure
- Shared package holds:
  - state enum `bs_state_t` with IDLE/PROBE/DONE;
  - the default `WIDTH` constant, also used by `cmp` and the benches.
- One module only. The midpoint adder is inline, and no sub-module is warranted.
- The `cmp` instance lives in the parent or top, not inside this block.

## Test plan
All scenarios use a bench with a real `cmp` instance comparing `guess` against secret `S`, with WIDTH=4.
1. S=7, pulse `start` → guess 7, `done` next edge, `result`=7, `steps`=1, `err`=0.
2. S=0 → guess sequence 7, 3, 1, 0, then `result`=0, `steps`=4. S=15 → sequence 7, 11, 13, 14, 15, then `steps`=5.
3. S=10 → sequence 7, 11, 9, 10, then `steps`=4. Pulse `start` again while `busy` → no restart and same sequence. Pulse `start` in DONE → new search begins at guess 7.
4. Force `lt`=`gt`=1 on the first probe → `done`=1, `err`=1, `steps`=1, `result` unchanged. Force all flags 0 → same. Force `lt` always → guesses 7, 11, 13, 14, 15, then `err`=1, `steps`=5.
5. Assert `rst` during the third probe of S=2 → next edge shows IDLE with all outputs 0. A following `start` completes normally with `result`=2.

Source files
------------

// File: rtl/bsearch_guess_pkg.sv
// Shared definitions for the binary-search guesser and its environment.
// Holds the default operand width (also used by cmp and the benches) and
// the guesser FSM state encoding.
package bsearch_guess_pkg;

  // Default operand width shared with the comparator and benches.
  localparam int unsigned BS_WIDTH = 4;

  // Legacy-compatible state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROBE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PROBE = ST_PROBE,
    DONE  = ST_DONE
  } bs_state_t;

endpackage

// File: rtl/bsearch_guess_if.sv
// Bundle between the guesser and its environment (controller + cmp).
// master: the guesser. It takes start and the cmp flags lt/gt/eq, and drives
//         guess, busy, done, err, result and steps.
// slave : the environment side, with every direction reversed.
interface bsearch_guess_if
  import bsearch_guess_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH
);

  localparam int unsigned SW = $clog2(WIDTH + 2);

  logic             start;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [SW-1:0]    steps;

  modport master (
    input  start, lt, gt, eq,
    output guess, busy, done, err, result, steps
  );

  modport slave (
    output start, lt, gt, eq,
    input  guess, busy, done, err, result, steps
  );

endinterface

// File: rtl/bsearch_guess.sv
// Binary-search guesser: drives the probe operand of a magnitude comparator
// and narrows [lo, hi] from its lt/gt/eq flags until the secret is found.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - bsearch_guess_if.master:
//            start       : begin a search (honoured in IDLE/DONE only)
//            lt/gt/eq    : comparator flags for the current guess
//            guess       : registered probe operand
//            busy / done : in PROBE / in DONE
//            err         : inconsistent flags or exhausted range (with done)
//            result      : located value (valid when done && !err)
//            steps       : probes evaluated in the last/current search
module bsearch_guess
  import bsearch_guess_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  bsearch_guess_if.master bus
);

  localparam int unsigned SW   = $clog2(WIDTH + 2);
  localparam int unsigned BW   = WIDTH + 1;
  localparam logic [BW-1:0] MAXV = BW'((1 << WIDTH) - 1);

  bs_state_t        state, state_n;
  logic [BW-1:0]    lo, lo_n;
  logic [BW-1:0]    hi, hi_n;
  logic [WIDTH-1:0] guess, guess_n;
  logic [WIDTH-1:0] result, result_n;
  logic [SW-1:0]    steps, steps_n;
  logic             err, err_n;
  logic             busy, busy_n;
  logic             done, done_n;

  logic [BW-1:0]    lo_upd;
  logic [BW-1:0]    hi_upd;
  logic [BW:0]      sum;
  logic             exhausted;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      steps  <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      result <= result_n;
      steps  <= steps_n;
      err    <= err_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Next-state, bound update and midpoint computation.
  always_comb begin
    state_n   = state;
    lo_n      = lo;
    hi_n      = hi;
    guess_n   = guess;
    result_n  = result;
    steps_n   = steps;
    err_n     = err;
    lo_upd    = lo;
    hi_upd    = hi;
    sum       = '0;
    exhausted = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = PROBE;
          lo_n    = '0;
          hi_n    = MAXV;
          steps_n = '0;
          err_n   = 1'b0;
          guess_n = WIDTH'(MAXV >> 1);
        end
      end

      PROBE: begin
        steps_n = steps + SW'(1);
        case ({bus.lt, bus.gt, bus.eq})
          3'b001: begin
            result_n = guess;
            err_n    = 1'b0;
            state_n  = DONE;
          end

          3'b100, 3'b010: begin
            if (bus.lt) begin
              lo_upd = BW'(guess) + BW'(1);
            end else if (guess == '0) begin
              // guess-1 would underflow: nothing left below the guess
              hi_upd    = '0;
              exhausted = 1'b1;
            end else begin
              hi_upd = BW'(guess) - BW'(1);
            end
            lo_n = lo_upd;
            hi_n = hi_upd;
            if (exhausted || (lo_upd > hi_upd)) begin
              err_n   = 1'b1;
              state_n = DONE;
            end else begin
              sum     = {1'b0, lo_upd} + {1'b0, hi_upd};
              guess_n = WIDTH'(sum >> 1);
            end
          end

          default: begin
            // no flag or several flags: comparator is inconsistent
            err_n   = 1'b1;
            state_n = DONE;
          end
        endcase
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == PROBE);
    done_n = (state_n == DONE);
  end

  assign bus.guess  = guess;
  assign bus.result = result;
  assign bus.steps  = steps;
  assign bus.err    = err;
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule

// File: tb/tb_bsearch_guess.sv
// Scoreboard bench for bsearch_guess with a behavioural 4-bit comparator.
// Stimulus pushes expected probes / completions into a queue; a negedge
// monitor pops and checks whenever the DUT shows a probe, a done rise, or idle.
module tb_bsearch_guess;
  import bsearch_guess_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = $clog2(W + 2);

  localparam int K_PROBE = 0;
  localparam int K_DONE  = 1;
  localparam int K_IDLE  = 2;

  typedef struct {
    int            kind;
    logic [W-1:0]  val;
    logic          err;
    logic [SW-1:0] steps;
  } exp_t;

  logic clk;
  logic rst;
  logic [W-1:0] secret;
  int           mode;   // 0 real cmp, 1 lt&gt, 2 no flag, 3 lt always
  exp_t         exp_q[$];
  int           total;
  int           bad;
  logic         done_prev;

  bsearch_guess_if #(.WIDTH(W)) bus ();

  bsearch_guess #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparator with optional forced flag patterns
  always_comb begin
    bus.lt = 1'b0;
    bus.gt = 1'b0;
    bus.eq = 1'b0;
    case (mode)
      1: begin bus.lt = 1'b1; bus.gt = 1'b1; end
      2: ;
      3: bus.lt = 1'b1;
      default: begin
        bus.lt = (bus.guess < secret);
        bus.gt = (bus.guess > secret);
        bus.eq = (bus.guess == secret);
      end
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // monitor
  initial done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check("busy_and_done_exclusive", int'(bus.busy && bus.done), 0);
    if (bus.busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_probe", int'(bus.guess), -1);
      end else begin
        e = exp_q.pop_front();
        check("probe_kind", e.kind, K_PROBE);
        check("probe_guess", int'(bus.guess), int'(e.val));
      end
    end
    if (bus.done === 1'b1 && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", int'(bus.result), -1);
      end else begin
        e = exp_q.pop_front();
        check("done_kind", e.kind, K_DONE);
        check("done_err", int'(bus.err), int'(e.err));
        check("done_steps", int'(bus.steps), int'(e.steps));
        check("done_result", int'(bus.result), int'(e.val));
      end
    end
    if (bus.busy === 1'b0 && bus.done === 1'b0 && exp_q.size() > 0) begin
      if (exp_q[0].kind == K_IDLE) begin
        e = exp_q.pop_front();
        check("idle_guess", int'(bus.guess), 0);
        check("idle_result", int'(bus.result), 0);
        check("idle_steps", int'(bus.steps), 0);
        check("idle_err", int'(bus.err), 0);
      end
    end
    done_prev = (bus.done === 1'b1);
  end

  task automatic push_probe(input logic [W-1:0] g);
    exp_t e;
    e.kind = K_PROBE; e.val = g; e.err = 1'b0; e.steps = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [W-1:0] r, input logic er, input int st);
    exp_t e;
    e.kind = K_DONE; e.val = r; e.err = er; e.steps = SW'(st);
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e.kind = K_IDLE; e.val = '0; e.err = 1'b0; e.steps = '0;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: %0d expected events left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic probes(input int n, input int g0, input int g1, input int g2,
                        input int g3, input int g4);
    int gs[5];
    gs[0] = g0; gs[1] = g1; gs[2] = g2; gs[3] = g3; gs[4] = g4;
    for (int i = 0; i < n; i++) push_probe(W'(gs[i]));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    secret    = '0;
    mode      = 0;

    push_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drain("reset");

    // S=7: one probe
    secret = 4'd7;
    probes(1, 7, 0, 0, 0, 0); push_done(4'd7, 1'b0, 1);
    pulse_start(); drain("s7");

    // S=0 and S=15 extremes
    secret = 4'd0;
    probes(4, 7, 3, 1, 0, 0); push_done(4'd0, 1'b0, 4);
    pulse_start(); drain("s0");
    secret = 4'd15;
    probes(5, 7, 11, 13, 14, 15); push_done(4'd15, 1'b0, 5);
    pulse_start(); drain("s15");

    // S=10 with a start pulse while busy (ignored)
    secret = 4'd10;
    probes(4, 7, 11, 9, 10, 0); push_done(4'd10, 1'b0, 4);
    pulse_start();
    pulse_start();
    drain("s10_busy_start");

    // restart from DONE
    probes(4, 7, 11, 9, 10, 0); push_done(4'd10, 1'b0, 4);
    pulse_start(); drain("s10_restart");

    // forced inconsistent flags: result holds 10
    mode = 1;
    probes(1, 7, 0, 0, 0, 0); push_done(4'd10, 1'b1, 1);
    pulse_start(); drain("lt_gt");
    mode = 2;
    probes(1, 7, 0, 0, 0, 0); push_done(4'd10, 1'b1, 1);
    pulse_start(); drain("no_flag");
    mode = 3;
    probes(5, 7, 11, 13, 14, 15); push_done(4'd10, 1'b1, 5);
    pulse_start(); drain("lt_always");
    mode = 0;

    // reset during third probe of S=2, then a clean search
    secret = 4'd2;
    probes(3, 7, 3, 1, 0, 0); push_idle();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;   // guess 7 now
    @(posedge clk);                        // guess 3
    @(posedge clk); #1 rst = 1'b1;         // guess 1, reset on next edge
    @(posedge clk); #1 rst = 1'b0;
    drain("mid_reset");
    probes(4, 7, 3, 1, 2, 0); push_done(4'd2, 1'b0, 4);
    pulse_start(); drain("s2_after_reset");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
